// File: rtl/ifu_align.sv
// rtl/ifu_align.sv - fetch-word to instruction aligner with registered decode output
// Compressed (16-bit) support is built only when IFU_ALIGN_RVC_EN is defined.
module ifu_align #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            fetch_valid,
    input  logic [31:0]     fetch_data,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            fetch_ready,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    output logic            compressed,
    input  logic            instr_ready
);

    logic            valid_q, valid_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            load;
    logic            emit;
    logic [31:0]     e_instr;
    logic [XLEN-1:0] e_pc;

    // The output register may take a new instruction when empty or being drained.
    assign load = !valid_q || instr_ready;

    assign instr_valid = valid_q;
    assign instr       = instr_q;
    assign instr_pc    = pc_q;

`ifdef IFU_ALIGN_RVC_EN
    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_HALF  = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [15:0]     res_q, res_d;
    logic [XLEN-1:0] rpc_q, rpc_d;
    logic            c_q, c_d;
    logic            e_c;

    function automatic logic is_c(input logic [1:0] lo);
        return lo != 2'b11;
    endfunction

    assign compressed = c_q;

    always_comb begin
        fetch_ready = 1'b0;
        emit        = 1'b0;
        e_instr     = instr_q;
        e_pc        = pc_q;
        e_c         = c_q;
        state_d     = state_q;
        res_d       = res_q;
        rpc_d       = rpc_q;
        if (flush) begin
            fetch_ready = 1'b1;
            state_d     = ST_EMPTY;
        end else if (state_q == ST_EMPTY) begin
            if (fetch_valid && fetch_pc[1]) begin
                // Jump into the upper halfword: keep it, nothing to emit yet.
                fetch_ready = 1'b1;
                state_d     = ST_HALF;
                res_d       = fetch_data[31:16];
                rpc_d       = fetch_pc;
            end else if (fetch_valid && load) begin
                fetch_ready = 1'b1;
                emit        = 1'b1;
                e_pc        = fetch_pc;
                if (is_c(fetch_data[1:0])) begin
                    e_instr = {16'h0000, fetch_data[15:0]};
                    e_c     = 1'b1;
                    state_d = ST_HALF;
                    res_d   = fetch_data[31:16];
                    rpc_d   = fetch_pc + XLEN'(2);
                end else begin
                    e_instr = fetch_data;
                    e_c     = 1'b0;
                end
            end
        end else begin
            if (is_c(res_q[1:0])) begin
                // Compressed residue drains on its own; the fetch word waits.
                if (load) begin
                    emit    = 1'b1;
                    e_instr = {16'h0000, res_q};
                    e_pc    = rpc_q;
                    e_c     = 1'b1;
                    state_d = ST_EMPTY;
                end
            end else if (fetch_valid && load) begin
                fetch_ready = 1'b1;
                emit        = 1'b1;
                e_instr     = {fetch_data[15:0], res_q};
                e_pc        = rpc_q;
                e_c         = 1'b0;
                res_d       = fetch_data[31:16];
                rpc_d       = rpc_q + XLEN'(4);
            end
        end
    end

    always_comb begin
        c_d = emit ? e_c : c_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            res_q   <= 16'h0000;
            rpc_q   <= '0;
            c_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            rpc_q   <= rpc_d;
            c_q     <= c_d;
        end
    end
`else
    assign compressed = 1'b0;

    always_comb begin
        fetch_ready = load || flush;
        emit        = 1'b0;
        e_instr     = instr_q;
        e_pc        = pc_q;
        if (!flush && fetch_valid && load) begin
            emit    = 1'b1;
            e_instr = fetch_data;
            e_pc    = fetch_pc;
        end
    end
`endif

    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (load) begin
            valid_d = emit;
        end
        instr_d = emit ? e_instr : instr_q;
        pc_d    = emit ? e_pc : pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            instr_q <= 32'h0;
            pc_q    <= '0;
        end else begin
            valid_q <= valid_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end

endmodule

// File: tb/tb_ifu_align.sv
// tb/tb_ifu_align.sv - self-checking bench for ifu_align (vector table plus instruction-stream scoreboard)
module tb_ifu_align;

`ifdef IFU_ALIGN_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        fetch_valid;
    logic [31:0] fetch_data;
    logic [31:0] fetch_pc;
    logic        fetch_ready;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        compressed;
    logic        instr_ready;

    int total = 0;
    int bad   = 0;

    ifu_align #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .fetch_valid(fetch_valid),
        .fetch_data (fetch_data),
        .fetch_pc   (fetch_pc),
        .fetch_ready(fetch_ready),
        .instr_valid(instr_valid),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .compressed (compressed),
        .instr_ready(instr_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        fl;
        logic        fv;
        logic [31:0] d;
        logic [31:0] pc;
        logic        rdy;
        logic        efr;
        logic        ev;
        logic [31:0] ei;
        logic [31:0] epc;
        logic        ec;
    } vec_t;

    typedef struct {
        logic [31:0] i;
        logic [31:0] pc;
        logic        c;
        int          e;
    } rec_t;

    vec_t        tv[$];
    rec_t        exp_l[$];
    rec_t        sb[$];
    logic [15:0] hw[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic add(input logic fl, input logic fv, input logic [31:0] d, input logic [31:0] pc,
                       input logic rdy, input logic efr, input logic ev, input logic [31:0] ei,
                       input logic [31:0] epc, input logic ec);
        vec_t v;
        v.fl = fl; v.fv = fv; v.d = d; v.pc = pc; v.rdy = rdy;
        v.efr = efr; v.ev = ev; v.ei = ei; v.epc = epc; v.ec = ec;
        tv.push_back(v);
    endtask

    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        flush       = v.fl;
        fetch_valid = v.fv;
        fetch_data  = v.d;
        fetch_pc    = v.pc;
        instr_ready = v.rdy;
        #1;
        chk({tag, "_fetch_ready"}, 64'(fetch_ready), 64'(v.efr));
        @(posedge clk);
        #1;
        chk({tag, "_valid"}, 64'(instr_valid), 64'(v.ev));
        if (v.ev) begin
            chk({tag, "_instr"}, 64'(instr), 64'(v.ei));
            chk({tag, "_pc"}, 64'(instr_pc), 64'(v.epc));
            chk({tag, "_c"}, 64'(compressed), 64'(v.ec));
        end
    endtask

    initial begin
        vec_t        v;
        rec_t        r;
        int          w, ptr, npop, nw;
        bit          done;
        logic [15:0] h, lo, hi;
        logic [31:0] base;

        rst_n = 1'b0; flush = 1'b0; fetch_valid = 1'b0; fetch_data = '0;
        fetch_pc = '0; instr_ready = 1'b0;
        #12;
        chk("rst_valid", 64'(instr_valid), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc", 64'(instr_pc), 64'd0);
        chk("rst_c", 64'(compressed), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef IFU_ALIGN_RVC_EN
        add(0,1,32'h00500093,32'h100,1, 1,1,32'h00500093,32'h100,0);
        add(0,1,32'h45014581,32'h200,1, 1,1,32'h00004581,32'h200,1);
        add(0,1,32'h00934501,32'h300,1, 0,1,32'h00004501,32'h202,1);
        add(0,1,32'h00934501,32'h300,1, 1,1,32'h00004501,32'h300,1);
        add(0,1,32'h12340001,32'h304,1, 1,1,32'h00010093,32'h302,0);
        for (int k = 0; k < 3; k++)
            add(0,1,32'h00a00113,32'h308,0, 0,1,32'h00010093,32'h302,0);
        add(0,1,32'h00a00113,32'h308,1, 0,1,32'h00001234,32'h306,1);
        add(0,1,32'h00a00113,32'h308,1, 1,1,32'h00a00113,32'h308,0);
        add(0,1,32'h12344581,32'h30c,1, 1,1,32'h00004581,32'h30c,1);
        add(1,1,32'hdeadbeef,32'h310,1, 1,0,32'h0,32'h0,0);
        add(0,1,32'h0001beef,32'h402,1, 1,0,32'h0,32'h0,0);
        add(0,0,32'h0,32'h0,1,          0,1,32'h00000001,32'h402,1);
        add(0,0,32'h0,32'h0,1,          0,0,32'h0,32'h0,0);
        add(0,1,32'h00500093,32'h500,1, 1,1,32'h00500093,32'h500,0);
        add(0,1,32'h00010000,32'h506,0, 1,1,32'h00500093,32'h500,0);
        add(0,0,32'h0,32'h0,1,          0,1,32'h00000001,32'h506,1);
        add(0,1,32'h00934501,32'hfffffffc,1, 1,1,32'h00004501,32'hfffffffc,1);
        add(0,1,32'h00000001,32'h0,1,   1,1,32'h00010093,32'hfffffffe,0);
        add(0,0,32'h0,32'h0,1,          0,1,32'h00000000,32'h00000002,1);
        add(1,1,32'h5555aaaa,32'h0,1,   1,0,32'h0,32'h0,0);
`else
        add(0,1,32'h00500093,32'h100,1, 1,1,32'h00500093,32'h100,0);
        add(0,1,32'h45014581,32'h200,1, 1,1,32'h45014581,32'h200,0);
        add(0,1,32'h12340001,32'h302,1, 1,1,32'h12340001,32'h302,0);
        for (int k = 0; k < 3; k++)
            add(0,1,32'hdeadbeef,32'h400,0, 0,1,32'h12340001,32'h302,0);
        add(0,1,32'hdeadbeef,32'h400,1, 1,1,32'hdeadbeef,32'h400,0);
        add(1,1,32'h11111111,32'h500,0, 1,0,32'h0,32'h0,0);
        add(0,0,32'h0,32'h0,0,          1,0,32'h0,32'h0,0);
        add(0,1,32'h0000ffff,32'hfffffffc,1, 1,1,32'h0000ffff,32'hfffffffc,0);
        add(0,0,32'h0,32'h0,1,          1,0,32'h0,32'h0,0);
        add(1,1,32'h5555aaaa,32'h0,1,   1,0,32'h0,32'h0,0);
`endif
        for (int i = 0; i < tv.size(); i++) apply(tv[i], $sformatf("v%0d", i));

        // Random instruction stream; expectations come from the generated program.
        base = 32'h0000_1000;
        if (RVC) hw.push_back(16'hffff);
        for (int k = 0; k < 48; k++) begin
            if (RVC && $urandom_range(0, 1) == 1) begin
                h = 16'($urandom);
                h[1:0] = 2'($urandom_range(0, 2));
                r.i = {16'h0000, h}; r.c = 1'b1;
                r.pc = base + 32'(2 * hw.size()); r.e = hw.size();
                hw.push_back(h);
            end else begin
                lo = 16'($urandom); lo[1:0] = 2'b11; hi = 16'($urandom);
                r.i = {hi, lo}; r.c = 1'b0;
                r.pc = base + 32'(2 * hw.size()); r.e = hw.size() + 1;
                hw.push_back(lo); hw.push_back(hi);
            end
            exp_l.push_back(r);
        end
        if (hw.size() % 2 == 1) begin
            r.i = 32'h0000_0001; r.c = 1'b1;
            r.pc = base + 32'(2 * hw.size()); r.e = hw.size();
            hw.push_back(16'h0001);
            exp_l.push_back(r);
        end
        nw = hw.size() / 2;
        w = 0; ptr = 0; npop = 0; done = 1'b0;
        for (int cyc = 0; cyc < 4000 && !done; cyc++) begin
            @(negedge clk);
            flush       = 1'b0;
            fetch_valid = (w < nw) && ($urandom_range(0, 3) != 0);
            fetch_data  = 32'h0;
            fetch_pc    = 32'h0;
            if (w < nw) begin
                fetch_data = {hw[2*w+1], hw[2*w]};
                fetch_pc   = (w == 0 && RVC) ? base + 32'd2 : base + 32'(4 * w);
            end
            instr_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (instr_valid && instr_ready) begin
                if (sb.size() == 0) begin
                    chk("sb_unexpected_instr", 64'(instr), 64'd0 - 64'd1);
                end else begin
                    r = sb.pop_front();
                    chk($sformatf("sb%0d", npop), {compressed, instr_pc, instr}, {r.c, r.pc, r.i});
                end
                npop++;
            end
            if (fetch_valid && fetch_ready) begin
                while (ptr < exp_l.size() && exp_l[ptr].e <= 2 * w + 1) begin
                    sb.push_back(exp_l[ptr]);
                    ptr++;
                end
                w++;
            end
            done = (w == nw) && (npop >= exp_l.size());
        end
        chk("sb_drain_count", 64'(npop), 64'(exp_l.size()));

        // Reset in mid-stream, then confirm the aligner restarts from EMPTY.
        v = '{fl:1, fv:1, d:32'h0, pc:32'h0, rdy:1, efr:1, ev:0, ei:32'h0, epc:32'h0, ec:0};
        apply(v, "pre_rst_flush");
        v = '{fl:0, fv:1, d:32'h12344581, pc:32'h600, rdy:1, efr:1, ev:1,
              ei:(RVC ? 32'h00004581 : 32'h12344581), epc:32'h600, ec:RVC};
        apply(v, "pre_rst");
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", 64'(instr_valid), 64'd0);
        chk("midrst_instr", 64'(instr), 64'd0);
        chk("midrst_pc", 64'(instr_pc), 64'd0);
        chk("midrst_c", 64'(compressed), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v = '{fl:0, fv:1, d:32'h00500093, pc:32'h700, rdy:1, efr:1, ev:1,
              ei:32'h00500093, epc:32'h700, ec:0};
        apply(v, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
